// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Power-up / re-lock sequencer for a PLL and two downstream reset domains.
// Everything runs on refclk, the free-running reference clock.
//
// Sequence:
//   PLL_RESET -> WAIT_LOCK -> STABLE -> RELEASE0 -> RUN
//
//   PLL_RESET  pll_rst is held high for PLL_RST_CYCLES cycles.
//   WAIT_LOCK  Waits for the synchronized lock indication.
//   STABLE     Requires LOCK_STABLE_CYCLES consecutive locked cycles.
//   RELEASE0   Releases rst_stage0 and holds rst_stage1 for STAGE_GAP cycles.
//   RUN        Both stage resets are released and ready is high.
//
// A loss of lock in RELEASE0 or RUN re-asserts both stage resets and returns
// to WAIT_LOCK without resetting the PLL. It also bumps the saturating
// lock_lost_cnt. A loss of lock in STABLE only restarts the stability count.
//
// Timing from the first refclk edge that samples pll_locked=1 (held high):
//   - rst_stage0 falls LOCK_STABLE_CYCLES+3 edges later.
//     This is 2 synchronizer edges, 1 edge to enter STABLE and
//     LOCK_STABLE_CYCLES counting edges.
//   - rst_stage1 falls and ready rises STAGE_GAP edges after that.
//
// Compile-time option:
//   PLL_LOCK_SEQ_TIMEOUT_EN  When defined, WAIT_LOCK gives up after
//                            LOCK_TIMEOUT_CYCLES cycles and re-pulses pll_rst.
//                            When undefined, the timeout counter does not exist
//                            and WAIT_LOCK waits forever.
//
// RELEASE1 keeps its encoding in the state type. The release path goes from
// RELEASE0 straight to RUN, so RELEASE1 is never entered. If the register ever
// holds RELEASE1 or an unused code, the sequencer recovers through a full PLL
// reset.

module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP           = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clr_cnt,
  output logic       pll_rst,
  output logic       rst_stage0,
  output logic       rst_stage1,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  // Counter widths. Each counter is sized to hold its terminal value.
  localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);

  // Terminal values for each counter.
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  // Reject parameter values outside their legal ranges at elaboration time.
  if (PLL_RST_CYCLES < 1) begin : g_bad_pll_rst_cycles
    $error("PLL_RST_CYCLES must be at least 1");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock_stable_cycles
    $error("LOCK_STABLE_CYCLES must be at least 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_stage_gap
    $error("STAGE_GAP must be at least 1");
  end
  if (LOCK_TIMEOUT_CYCLES < 2) begin : g_bad_lock_timeout_cycles
    $error("LOCK_TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE0  = 3'd3,
    ST_RELEASE1  = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  // Synchronizer flops. locked_s_q is the only lock view the logic uses.
  logic sync1_q;
  logic locked_s_q;

  // State register.
  state_t state_q;

  // Per-state counters.
  logic [RST_W-1:0]  rst_cnt_q;
  logic [STAB_W-1:0] stab_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]   to_cnt_q;
`endif

  // Registered outputs.
  logic       pll_rst_q;
  logic       rst_stage0_q;
  logic       rst_stage1_q;
  logic       ready_q;
  logic [7:0] lost_cnt_q;

  // A loss event is lock dropping while downstream logic is being released or
  // is running. Drops during WAIT_LOCK or STABLE are not counted.
  logic loss_evt;
  assign loss_evt = ((state_q == ST_RELEASE0) || (state_q == ST_RUN)) && !locked_s_q;

  // Two-flop synchronizer for the asynchronous pll_locked input.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Sequencer FSM. It also updates the counters, the registered outputs and the
  // lock-loss counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= ST_PLL_RESET;
      rst_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      gap_cnt_q    <= '0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
      pll_rst_q    <= 1'b1;
      rst_stage0_q <= 1'b1;
      rst_stage1_q <= 1'b1;
      ready_q      <= 1'b0;
      lost_cnt_q   <= 8'd0;
    end else begin
      // Lock-loss counter. A clear that coincides with a loss keeps the loss.
      if (loss_evt && clr_cnt) begin
        lost_cnt_q <= 8'd1;
      end else if (loss_evt) begin
        if (lost_cnt_q != 8'hFF) begin
          lost_cnt_q <= lost_cnt_q + 8'd1;
        end
      end else if (clr_cnt) begin
        lost_cnt_q <= 8'd0;
      end

      case (state_q)
        ST_PLL_RESET: begin
          // Hold the PLL and both stages in reset for the full pulse width.
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            pll_rst_q <= 1'b0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_q    <= ST_STABLE;
            stab_cnt_q <= '0;
          end
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            // The PLL never locked in time: reset it again.
            state_q   <= ST_PLL_RESET;
            rst_cnt_q <= '0;
            pll_rst_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end

        ST_STABLE: begin
          if (!locked_s_q) begin
            // Lock bounced: go back and wait, with a fresh timeout window.
            state_q  <= ST_WAIT_LOCK;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else if (stab_cnt_q == STAB_LAST) begin
            state_q      <= ST_RELEASE0;
            rst_stage0_q <= 1'b0;
            gap_cnt_q    <= '0;
          end else begin
            stab_cnt_q <= stab_cnt_q + STAB_W'(1);
          end
        end

        ST_RELEASE0: begin
          if (!locked_s_q) begin
            state_q      <= ST_WAIT_LOCK;
            rst_stage0_q <= 1'b1;
            rst_stage1_q <= 1'b1;
            ready_q      <= 1'b0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
          end else if (gap_cnt_q == GAP_LAST) begin
            state_q      <= ST_RUN;
            rst_stage1_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        ST_RUN: begin
          if (!locked_s_q) begin
            state_q      <= ST_WAIT_LOCK;
            rst_stage0_q <= 1'b1;
            rst_stage1_q <= 1'b1;
            ready_q      <= 1'b0;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
          end
        end

        default: begin
          // RELEASE1 or an unused code: recover through a full PLL reset.
          state_q      <= ST_PLL_RESET;
          rst_cnt_q    <= '0;
          pll_rst_q    <= 1'b1;
          rst_stage0_q <= 1'b1;
          rst_stage1_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_stage0    = rst_stage0_q;
  assign rst_stage1    = rst_stage1_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer.
// DUT parameters: PLL_RST_CYCLES=3, LOCK_STABLE_CYCLES=4, STAGE_GAP=2,
// LOCK_TIMEOUT_CYCLES=20.
// A vector table drives reset, lock-up and one lock loss cycle by cycle.
// Hand-written sequences then cover the longer corner cases.

module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       pll_rst;
  logic       rst_stage0;
  logic       rst_stage1;
  logic       ready;
  logic [7:0] lock_lost_cnt;

  int n_pass = 0;
  int n_total = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (3),
    .LOCK_STABLE_CYCLES (4),
    .STAGE_GAP          (2),
    .LOCK_TIMEOUT_CYCLES(20)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .clr_cnt      (clr_cnt),
    .pll_rst      (pll_rst),
    .rst_stage0   (rst_stage0),
    .rst_stage1   (rst_stage1),
    .ready        (ready),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 refclk = ~refclk;

  // Each row holds the inputs applied before one edge and the expected
  // outputs after that edge. exp_o packs {pll_rst, rst_stage0, rst_stage1, ready}.
  typedef struct packed {
    logic       rst;
    logic       lk;
    logic       clr;
    logic [3:0] exp_o;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [0:20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {pll_rst, rst_stage0, rst_stage1, ready};
  endfunction

  // Reset for 2 cycles, then run the 3-cycle PLL reset with lock low.
  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    clr_cnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // From WAIT_LOCK with lock low: raise lock and hold it until RUN (10 edges).
  task automatic lock_up();
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  // From RUN: drop lock. The loss is registered on the 3rd edge.
  // clr_cnt is applied on that edge when clr is set.
  task automatic lose(input logic clr);
    pll_locked = 1'b0;
    tick();
    tick();
    clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    int   n;
    int   hi_cnt;
    int   first_rise;
    int   second_rise;
    logic prev;
    logic run_ok;
    logic no_pll_rst;

    //                rst   lk    clr   {P,S0,S1,R}  cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1110, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b1110, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b1110, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b1110, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0110, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0110, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0110, 8'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'b0010, 8'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'b0010, 8'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'b0001, 8'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 4'b0001, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'b0001, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 4'b0110, 8'd1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 4'b0110, 8'd0};

    for (int i = 0; i <= 20; i++) begin
      rst = vecs[i].rst;
      pll_locked = vecs[i].lk;
      clr_cnt = vecs[i].clr;
      tick();
      check($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d cnt", i), 32'(lock_lost_cnt), 32'(vecs[i].exp_cnt));
    end
    clr_cnt = 1'b0;

    // A 1-cycle lock glitch during STABLE restarts the stability count.
    // Release moves from edge 7 to edge 12 (0-based from the first lock sample).
    pll_locked = 1'b1;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) pll_locked = 1'b0;
      if (i == 6) pll_locked = 1'b1;
      tick();
      if (rst_stage0 == 1'b0) begin
        n = i;
        break;
      end
    end
    check("glitch s0 fall tick", 32'(n), 32'd13);
    check("glitch s1/ready at s0 fall", 32'({rst_stage1, ready}), 32'(2'b10));
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ready == 1'b1) begin
        n = i;
        break;
      end
    end
    check("glitch ready delay", 32'(n), 32'd2);
    check("glitch s1 with ready", 32'(rst_stage1), 32'd0);
    check("glitch cnt unchanged", 32'(lock_lost_cnt), 32'd0);

    // 300 lock losses from RUN. The counter must saturate at 255.
    // The PLL must never be reset by these losses.
    run_ok = 1'b1;
    no_pll_rst = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      lose(1'b0);
      if (pll_rst) no_pll_rst = 1'b0;
      if (k == 1) begin
        check("loss1 outs", 32'(outs()), 32'(4'b0110));
        check("loss1 cnt", 32'(lock_lost_cnt), 32'd1);
      end
      if (k == 254) check("loss254 cnt", 32'(lock_lost_cnt), 32'd254);
      lock_up();
      if (pll_rst) no_pll_rst = 1'b0;
      if (ready !== 1'b1) run_ok = 1'b0;
    end
    check("loss300 cnt saturated", 32'(lock_lost_cnt), 32'd255);
    check("relock reached RUN each time", 32'(run_ok), 32'd1);
    check("no pll_rst on lock loss", 32'(no_pll_rst), 32'd1);

    // Reset in the middle of RUN takes effect on the same edge.
    rst = 1'b1;
    tick();
    check("mid-run rst outs", 32'(outs()), 32'(4'b1110));
    check("mid-run rst cnt", 32'(lock_lost_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post-rst pll_rst t1", 32'(pll_rst), 32'd1);
    tick();
    check("post-rst pll_rst t2", 32'(pll_rst), 32'd1);
    tick();
    check("post-rst pll_rst t3", 32'(outs()), 32'(4'b0110));

    // clr_cnt on the same edge as a loss gives 1.
    // clr_cnt alone afterwards gives 0.
    lock_up();
    for (int k = 0; k < 5; k++) begin
      lose(1'b0);
      lock_up();
    end
    check("cnt before clr", 32'(lock_lost_cnt), 32'd5);
    lose(1'b1);
    check("clr with loss", 32'(lock_lost_cnt), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr alone", 32'(lock_lost_cnt), 32'd0);

    // Hold lock low after a reset and watch for pll_rst re-pulses.
    do_reset();
    hi_cnt = 0;
    first_rise = -1;
    second_rise = -1;
    prev = pll_rst;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (pll_rst) hi_cnt++;
      if (pll_rst && !prev) begin
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev = pll_rst;
    end
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
    check("timeout first re-pulse", 32'(first_rise), 32'd20);
    check("timeout period", 32'(second_rise - first_rise), 32'd23);
    check("timeout pll_rst high cycles", 32'(hi_cnt), 32'd6);
`else
    check("no timeout re-pulse", 32'(hi_cnt), 32'd0);
    check("no timeout rise", 32'(first_rise), 32'hFFFF_FFFF);
`endif
    check("stages held without lock", 32'({rst_stage0, rst_stage1, ready}), 32'(3'b110));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
